glcd_stream_ctrl: RTL and testbench
===================================

GLCD_STREAM_CTRL -- requirements
Module: glcd_stream_ctrl

Interface
REQ-001 Parameter NUM_CS, 2, number of KS0108-type controller segments on the panel (1..4).
REQ-002 Parameter PAGES, 8, 8-pixel pages per segment.
REQ-003 Parameter COLS, 64, columns per segment.
REQ-004 Parameter EN_CYCLES, 4, clk cycles LCD_en is held high, and then held low, per bus transfer.
REQ-005 Parameter RST_CYCLES, 16, clk cycles LCD_rst is held low after reset.
REQ-006 Parameter CLEAR_ON_INIT, 1, when 1 the whole panel is written with 0x00 during init.
REQ-007 Port clk, input, 1, single clock for all logic.
REQ-008 Port rst_n, input, 1, reset: synchronous and active-low.
REQ-009 Port data, input, 8, pixel byte for one column of one page, LSB = top row.
REQ-010 Port data_valid, input, 1, data holds a valid byte.
REQ-011 Port data_ready, output, 1, block accepts data this cycle.
REQ-012 Port frame_start, input, 1, single-cycle request to restart the write position at page 0, segment 0, column 0.
REQ-013 Port busy, output, 1, high during init or an active bus transfer.
REQ-014 Port frame_done, output, 1, one-cycle pulse after the last byte of a frame completes.
REQ-015 Ports LCD_rst (1), LCD_cs (NUM_CS), LCD_rw (1), LCD_di (1), LCD_data (8), LCD_en (1), outputs, panel bus.

Function
REQ-016 Every bus transfer SHALL: drive LCD_cs/LCD_di/LCD_data from cycle t+1, LCD_en high t+1..t+EN_CYCLES, low t+EN_CYCLES+1..t+2*EN_CYCLES, with bus values stable throughout.
REQ-017 LCD_rw SHALL be 0 at all times.
REQ-018 FSM states SHALL be: RST_HOLD -> DISP_ON (0x3F, all cs high) -> START_LINE (0xC0, all cs high) -> [CLEAR, if CLEAR_ON_INIT] -> SET_PAGE -> SET_COL -> WAIT_DATA -> WRITE -> back to WAIT_DATA / SET_PAGE / SET_COL.
REQ-019 Commands SHALL use LCD_di=0; page command SHALL be 0xB8|page, column command 0x40|0 with only the current segment's LCD_cs bit high.
REQ-020 CLEAR SHALL write 0x00 to every page/column of every segment without consuming stream data, using the same transfer timing.
REQ-021 Stream order SHALL be page-major: for page 0..PAGES-1, for segment 0..NUM_CS-1, COLS data bytes (LCD_di=1) relying on panel column auto-increment; SET_PAGE/SET_COL issued at each segment change.
REQ-022 data_ready SHALL be high only in WAIT_DATA while frame_start is low; a byte is accepted when data_valid && data_ready.
REQ-023 Accepted byte SHALL be registered on acceptance; data_ready SHALL reassert no earlier than cycle t+2*EN_CYCLES+1.
REQ-024 After the last byte (page PAGES-1, segment NUM_CS-1, column COLS-1) frame_done SHALL pulse once at the end of its low phase and the position SHALL wrap to page 0, segment 0.
REQ-025 frame_start during a transfer SHALL let the transfer finish, then go to SET_PAGE at page 0/segment 0; no frame_done is produced for the aborted frame.
REQ-026 frame_start coincident with data_valid SHALL win; the byte is not accepted.
REQ-027 frame_start during init SHALL be ignored.
REQ-028 Column/page/segment counters SHALL be sized $clog2 of their parameter and never exceed parameter-1.

Reset
REQ-029 While rst_n=0 at a clk edge: LCD_rst=0, LCD_cs=0, LCD_rw=0, LCD_di=0, LCD_data=0x00, LCD_en=0, data_ready=0, busy=1, frame_done=0, counters 0, state RST_HOLD.
REQ-030 After release LCD_rst SHALL stay 0 for RST_CYCLES cycles, then 1; reset mid-transfer SHALL abort immediately.

Structure
REQ-031 Package glcd_pkg SHALL hold command opcodes (0x3F, 0xC0, 0xB8, 0x40) and the FSM state enum.
REQ-032 The enable-timing engine SHALL be sub-module glcd_bus_xfer (start/done handshake, EN_CYCLES counter).

Verification
REQ-033 Reset release, defaults -> LCD_rst low 16 cycles, then 0x3F then 0xC0 with LCD_cs=2'b11, each en high 4 / low 4.
REQ-034 CLEAR_ON_INIT=1 -> exactly 8*2*64 (+command) transfers of 0x00 before first data_ready.
REQ-035 Stream 1024 bytes 0x00..0xFF repeating, valid always high -> page/column commands at each 64-byte boundary, cs alternating 01/10, one frame_done, wrap to 0xB8.
REQ-036 frame_start at byte 100 with data_valid high -> byte 100 not accepted, next transfers 0xB8 then 0x40 on cs=01, no frame_done.
REQ-037 NUM_CS=1, PAGES=2, COLS=4, EN_CYCLES=1 -> 8 bytes per frame, frame_done every 8 bytes plus 4 commands.
REQ-038 rst_n low during a WRITE en-high phase -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/glcd_pkg.sv
// Shared opcodes and FSM state encoding for the KS0108-style panel streamer.
package glcd_pkg;
  localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
  localparam logic [7:0] CMD_SET_COL    = 8'h40;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST_HOLD   = 3'd0;
  localparam state_t ST_DISP_ON    = 3'd1;
  localparam state_t ST_START_LINE = 3'd2;
  localparam state_t ST_CLEAR      = 3'd3;
  localparam state_t ST_SET_PAGE   = 3'd4;
  localparam state_t ST_SET_COL    = 3'd5;
  localparam state_t ST_WAIT_DATA  = 3'd6;
  localparam state_t ST_WRITE      = 3'd7;

  // States up to CLEAR belong to the power-up sequence.
  function automatic logic is_init(input state_t st);
    return st <= ST_CLEAR;
  endfunction
endpackage

// File: rtl/glcd_bus_xfer.sv
// One panel bus transfer: latch cs/di/data on start, en high EN_CYCLES then low EN_CYCLES.
module glcd_bus_xfer #(
  parameter int NUM_CS    = 2,
  parameter int EN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CS-1:0] cmd_cs,
  input  logic              cmd_di,
  input  logic [7:0]        cmd_data,
  output logic              active,
  output logic              done,
  output logic [NUM_CS-1:0] bus_cs,
  output logic              bus_di,
  output logic [7:0]        bus_data,
  output logic              bus_en
);
  localparam int CW = $clog2(2*EN_CYCLES+1);
  localparam logic [CW-1:0] LAST   = CW'(2*EN_CYCLES);
  localparam logic [CW-1:0] HI_END = CW'(EN_CYCLES);

  logic [CW-1:0] cnt;

  // cnt is the cycle index within the transfer, 1..2*EN_CYCLES
  assign done = active && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      bus_cs   <= '0;
      bus_di   <= 1'b0;
      bus_data <= 8'h00;
      bus_en   <= 1'b0;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
        bus_en <= 1'b0;
      end else begin
        cnt    <= cnt + 1'b1;
        bus_en <= (cnt < HI_END);
      end
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= CW'(1);
      bus_en   <= 1'b1;
      bus_cs   <= cmd_cs;
      bus_di   <= cmd_di;
      bus_data <= cmd_data;
    end
  end
endmodule

// File: rtl/glcd_stream_ctrl.sv
// Streams page-major pixel bytes to a multi-segment KS0108 panel, with power-up init and optional clear.
module glcd_stream_ctrl
  import glcd_pkg::*;
#(
  parameter int NUM_CS        = 2,
  parameter int PAGES         = 8,
  parameter int COLS          = 64,
  parameter int EN_CYCLES     = 4,
  parameter int RST_CYCLES    = 16,
  parameter int CLEAR_ON_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        data,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              LCD_rst,
  output logic [NUM_CS-1:0] LCD_cs,
  output logic              LCD_rw,
  output logic              LCD_di,
  output logic [7:0]        LCD_data,
  output logic              LCD_en
);
  localparam int PW = (PAGES  > 1) ? $clog2(PAGES)  : 1;
  localparam int SW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CW = (COLS   > 1) ? $clog2(COLS)   : 1;
  localparam int RW = $clog2(RST_CYCLES+1);

  state_t            state;
  logic [PW-1:0]     page;
  logic [SW-1:0]     seg;
  logic [CW-1:0]     col;
  logic [RW-1:0]     rst_cnt;
  logic              rst_q, launched, clearing, fs_pend;

  logic              start, xfer_active, xfer_done;
  logic [NUM_CS-1:0] cmd_cs, seg_cs;
  logic              cmd_di;
  logic [7:0]        cmd_data;
  logic              last_col, last_seg, last_page, streaming, abort, accept;

  assign seg_cs    = NUM_CS'(1) << seg;
  assign last_col  = (col  == CW'(COLS-1));
  assign last_seg  = (seg  == SW'(NUM_CS-1));
  assign last_page = (page == PW'(PAGES-1));
  assign streaming = !is_init(state) && !clearing;
  // A restart request is honoured only at a transfer boundary or while idle.
  assign abort     = streaming && (fs_pend || frame_start);

  assign data_ready = (state == ST_WAIT_DATA) && !frame_start && !fs_pend;
  assign accept     = data_ready && data_valid;
  assign busy       = is_init(state) || clearing || xfer_active;
  assign frame_done = xfer_done && (state == ST_WRITE) && last_col && last_seg
                      && last_page && !abort;
  assign LCD_rst    = rst_q;
  assign LCD_rw     = 1'b0;

  always_comb begin
    cmd_cs   = seg_cs;
    cmd_di   = 1'b0;
    cmd_data = 8'h00;
    start    = 1'b0;
    case (state)
      ST_DISP_ON:    begin cmd_cs = '1; cmd_data = CMD_DISP_ON;    start = !launched; end
      ST_START_LINE: begin cmd_cs = '1; cmd_data = CMD_START_LINE; start = !launched; end
      ST_SET_PAGE:   begin cmd_data = CMD_SET_PAGE | 8'(page);     start = !launched; end
      ST_SET_COL:    begin cmd_data = CMD_SET_COL;                 start = !launched; end
      ST_CLEAR:      begin cmd_di = 1'b1;                          start = !launched; end
      ST_WAIT_DATA:  begin cmd_di = 1'b1; cmd_data = data;         start = accept;    end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RST_HOLD;
      page     <= '0;
      seg      <= '0;
      col      <= '0;
      rst_cnt  <= '0;
      rst_q    <= 1'b0;
      launched <= 1'b0;
      clearing <= 1'b0;
      fs_pend  <= 1'b0;
    end else begin
      if (start)                    launched <= 1'b1;
      if (xfer_done)                launched <= 1'b0;
      if (streaming && frame_start) fs_pend  <= 1'b1;
      case (state)
        ST_RST_HOLD:
          if (rst_cnt == RW'(RST_CYCLES-1)) begin
            rst_q <= 1'b1;
            state <= ST_DISP_ON;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        ST_DISP_ON:
          if (xfer_done) state <= ST_START_LINE;
        ST_START_LINE:
          if (xfer_done) begin
            clearing <= (CLEAR_ON_INIT != 0);
            state    <= ST_SET_PAGE;
          end
        ST_SET_PAGE, ST_SET_COL:
          if (xfer_done) begin
            if (abort) begin
              {page, seg, col} <= '0;
              fs_pend <= 1'b0;
              state   <= ST_SET_PAGE;
            end else if (state == ST_SET_PAGE) begin
              state <= ST_SET_COL;
            end else begin
              state <= clearing ? ST_CLEAR : ST_WAIT_DATA;
            end
          end
        ST_WAIT_DATA:
          if (abort) begin
            {page, seg, col} <= '0;
            fs_pend <= 1'b0;
            state   <= ST_SET_PAGE;
          end else if (accept) begin
            state <= ST_WRITE;
          end
        default: // ST_CLEAR, ST_WRITE: advance position once the byte is on the panel
          if (xfer_done) begin
            if (abort) begin
              {page, seg, col} <= '0;
              fs_pend <= 1'b0;
              state   <= ST_SET_PAGE;
            end else if (!last_col) begin
              col   <= col + 1'b1;
              state <= clearing ? ST_CLEAR : ST_WAIT_DATA;
            end else begin
              col   <= '0;
              state <= ST_SET_PAGE;
              if (!last_seg) begin
                seg <= seg + 1'b1;
              end else begin
                seg <= '0;
                if (last_page) begin
                  page     <= '0;
                  clearing <= 1'b0;
                end else begin
                  page <= page + 1'b1;
                end
              end
            end
          end
      endcase
    end
  end

  glcd_bus_xfer #(.NUM_CS(NUM_CS), .EN_CYCLES(EN_CYCLES)) u_xfer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd_cs   (cmd_cs),
    .cmd_di   (cmd_di),
    .cmd_data (cmd_data),
    .active   (xfer_active),
    .done     (xfer_done),
    .bus_cs   (LCD_cs),
    .bus_di   (LCD_di),
    .bus_data (LCD_data),
    .bus_en   (LCD_en)
  );
endmodule

// File: tb/tb_glcd_stream_ctrl.sv
// Scoreboard bench: default panel plus a tiny 1-segment panel sharing clock and reset.
module tb_glcd_stream_ctrl;
  localparam int NCS = 2, PAGES = 8, COLS = 64, EN = 4, FRAME = NCS*PAGES*COLS;

  typedef struct packed {
    logic [1:0] cs;
    logic       di;
    logic [7:0] d;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0, frame_start = 1'b0;
  logic       data_ready, busy, frame_done;
  logic       LCD_rst, LCD_rw, LCD_di, LCD_en;
  logic [1:0] LCD_cs;
  logic [7:0] LCD_data;

  logic       s_ready, s_busy, s_fd, s_rst, s_rw, s_di, s_en;
  logic [0:0] s_cs;
  logic [7:0] s_data = 8'h00, s_lcd_data;
  logic       s_valid = 1'b1, s_acc = 1'b0;

  always #5 clk = ~clk;

  glcd_stream_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .LCD_rst(LCD_rst), .LCD_cs(LCD_cs), .LCD_rw(LCD_rw),
    .LCD_di(LCD_di), .LCD_data(LCD_data), .LCD_en(LCD_en)
  );

  glcd_stream_ctrl #(.NUM_CS(1), .PAGES(2), .COLS(4), .EN_CYCLES(1),
                     .RST_CYCLES(4), .CLEAR_ON_INIT(0)) u_small (
    .clk(clk), .rst_n(rst_n), .data(s_data), .data_valid(s_valid),
    .data_ready(s_ready), .frame_start(1'b0), .busy(s_busy),
    .frame_done(s_fd), .LCD_rst(s_rst), .LCD_cs(s_cs), .LCD_rw(s_rw),
    .LCD_di(s_di), .LCD_data(s_lcd_data), .LCD_en(s_en)
  );

  int    vec = 0, err = 0;
  xfer_t exp_q[$];
  int    k = 0, fd_exp = 0, fd_seen = 0;
  bit    mon_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: panel address derived from the byte index within the frame.
  task automatic push(input logic [1:0] cs, input logic di, input logic [7:0] d);
    exp_q.push_back('{cs: cs, di: di, d: d});
  endtask

  task automatic push_addr(input int kk);
    int p = kk / (NCS*COLS);
    int s = (kk / COLS) % NCS;
    push(2'(1 << s), 1'b0, 8'hB8 | 8'(p));
    push(2'(1 << s), 1'b0, 8'h40);
  endtask

  task automatic model_byte(input logic [7:0] b);
    push(2'(1 << ((k / COLS) % NCS)), 1'b1, b);
    k++;
    if (k == FRAME) begin
      k = 0;
      fd_exp++;
    end
    if (k % COLS == 0) push_addr(k);
  endtask

  task automatic model_restart();
    k = 0;
    push_addr(0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b, input bit rnd);
    int tmo = 0;
    data = b;
    forever begin
      data_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (data_valid && data_ready) break;
      @(negedge clk);
      if (++tmo > 300) begin
        chk("accept_timeout", 0, 1);
        return;
      end
    end
    model_byte(b);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Bus monitor for the default panel: pops the scoreboard on every en rise.
  initial begin
    bit    en_q = 1'b0;
    int    hi = 0, lo = 0, n_xfer = 0;
    xfer_t cur, e;
    forever begin
      @(negedge clk);
      if (!mon_on) begin en_q = 1'b0; continue; end
      chk("lcd_rw", LCD_rw, 0);
      if (LCD_en && !en_q) begin
        if (n_xfer > 0) chk("en_low_min", int'(lo >= EN), 1);
        hi = 1; lo = 0; n_xfer++;
        cur = '{cs: LCD_cs, di: LCD_di, d: LCD_data};
        if (exp_q.size() == 0) chk("unexpected_xfer", {LCD_cs, LCD_di, LCD_data}, 0);
        else begin
          e = exp_q.pop_front();
          chk("xfer_cs", LCD_cs, e.cs);
          chk("xfer_di", LCD_di, e.di);
          chk("xfer_data", LCD_data, e.d);
        end
        chk("busy_in_xfer", busy, 1);
      end else if (LCD_en) begin
        hi++;
        chk("bus_stable_hi", {LCD_cs, LCD_di, LCD_data}, cur);
      end else begin
        if (en_q) begin
          chk("en_high_len", hi, EN);
          lo = 1;
        end else if (lo < 1000) lo++;
        if (lo <= EN && n_xfer > 0) chk("bus_stable_lo", {LCD_cs, LCD_di, LCD_data}, cur);
      end
      if (frame_done) begin
        fd_seen++;
        chk("frame_done_due", int'(fd_seen <= fd_exp), 1);
        chk("frame_done_phase", lo, EN);
      end
      en_q = LCD_en;
    end
  end

  // Tiny panel: counting source, each frame is 8 bytes framed by 4 address commands.
  initial begin
    bit   en_q = 1'b0;
    logic [7:0] s_exp = 8'h00;
    int   nd = 0, nc = 0;
    forever begin
      @(negedge clk);
      if (s_acc) s_data = s_data + 8'd1;
      s_acc = s_ready && s_valid;
      if (!mon_on) begin en_q = 1'b0; continue; end
      if (s_en && !en_q) begin
        if (s_di) begin
          chk("s_data", s_lcd_data, s_exp);
          s_exp = s_exp + 8'd1;
          nd++;
        end else if (s_lcd_data != 8'h3F && s_lcd_data != 8'hC0) begin
          chk("s_cmd_cs", s_cs, 1);
          nc++;
        end
      end
      if (s_fd) begin
        chk("s_frame_bytes", nd, 8);
        chk("s_frame_cmds", nc, 4);
        nd = 0; nc = 0;
      end
      en_q = s_en;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_lcd_rst", LCD_rst, 0);
    chk("rst_cs", LCD_cs, 0);
    chk("rst_rw", LCD_rw, 0);
    chk("rst_di", LCD_di, 0);
    chk("rst_data", LCD_data, 0);
    chk("rst_en", LCD_en, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_frame_done", frame_done, 0);

    push(2'b11, 1'b0, 8'h3F);
    push(2'b11, 1'b0, 8'hC0);
    for (int kk = 0; kk < FRAME; kk++) begin
      if (kk % COLS == 0) push_addr(kk);
      push(2'(1 << ((kk / COLS) % NCS)), 1'b1, 8'h00);
    end
    push_addr(0);
    mon_on = 1'b1;
    rst_n  = 1'b1;
    n = 0;
    while (LCD_rst === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("rst_low_cycles", n, 16);

    // frame_start during init must not disturb the clear sequence
    repeat (500) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;

    n = 0;
    while (!data_ready && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("init_ready_seen", data_ready, 1);
    chk("init_xfers_left", exp_q.size(), 0);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < FRAME; i++) send(8'(i), 1'b0);

    for (int i = 0; i < 100; i++) send(8'($urandom), 1'b1);
    n = 0;
    while (!data_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("abort_ready_before", data_ready, 1);
    data = 8'h55;
    data_valid = 1'b1;
    frame_start = 1'b1;
    #1;
    chk("abort_ready_blocked", data_ready, 0);
    @(negedge clk);
    frame_start = 1'b0;
    data_valid = 1'b0;
    model_restart();

    for (int i = 0; i < 11; i++) send(8'($urandom), 1'b1);
    @(negedge clk);
    chk("abort_mid_xfer_en", LCD_en, 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    model_restart();

    for (int i = 0; i < FRAME; i++) send(8'($urandom), 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frame_done_count", fd_seen, fd_exp);
    chk("frame_done_expected", fd_exp, 2);

    send(8'hA5, 1'b0);
    chk("pre_reset_en", LCD_en, 1);
    mon_on = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_lcd_rst", LCD_rst, 0);
    chk("mid_rst_cs", LCD_cs, 0);
    chk("mid_rst_di", LCD_di, 0);
    chk("mid_rst_data", LCD_data, 0);
    chk("mid_rst_en", LCD_en, 0);
    chk("mid_rst_ready", data_ready, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_frame_done", frame_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
